// File: rtl/uart_pkg.sv
// Shared UART constants: character width, default RX FIFO depth and the
// bit layout of the peripheral status register.
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int UART_RX_FIFO_DEPTH_DEF = 16;

    localparam int STAT_EMPTY_BIT   = 0;
    localparam int STAT_FULL_BIT    = 1;
    localparam int STAT_OVERRUN_BIT = 2;
    localparam int STAT_COUNT_LSB   = 8;

    typedef struct packed {
        logic       overrun;
        logic       full;
        logic       empty;
    } rx_flags_t;

    // Packs FIFO status into the 32-bit word the bus side reads back.
    function automatic logic [31:0] rx_status_word(input rx_flags_t flags,
                                                   input logic [8:0] count);
        logic [31:0] word_v;
        word_v                   = 32'h0000_0000;
        word_v[STAT_EMPTY_BIT]   = flags.empty;
        word_v[STAT_FULL_BIT]    = flags.full;
        word_v[STAT_OVERRUN_BIT] = flags.overrun;
        word_v[STAT_COUNT_LSB +: 9] = count;
        return word_v;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO handshake bundle: master drives receiver/bus strobes, slave is the FIFO.
// irq is present only when UART_RX_FIFO_IRQ_EN is defined.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH_DEF,
    parameter int DATA_W = UART_DATA_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              pop;
    logic              flush;
    logic              clr_overrun;
    logic [DATA_W-1:0] out_data;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overrun;
`ifdef UART_RX_FIFO_IRQ_EN
    logic              irq;

    modport master (output in_valid, in_data, pop, flush, clr_overrun,
                    input  out_data, empty, full, count, overrun, irq);
    modport slave  (input  in_valid, in_data, pop, flush, clr_overrun,
                    output out_data, empty, full, count, overrun, irq);
`else
    modport master (output in_valid, in_data, pop, flush, clr_overrun,
                    input  out_data, empty, full, count, overrun);
    modport slave  (input  in_valid, in_data, pop, flush, clr_overrun,
                    output out_data, empty, full, count, overrun);
`endif

endinterface

// File: rtl/uart_edge_detect.sv
// Registers a ready level and emits a one-cycle pulse on its rising edge;
// shared by the RX capture path and tx_ready handling.
module uart_edge_detect
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_r;

    // Previous-cycle copy of the level, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_r <= 1'b0;
        end else begin
            din_r <= din;
        end
    end

    assign rise = din & ~din_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word fall-through head, occupancy flags and sticky overrun.
// Optional threshold interrupt enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH_DEF,
    parameter int DATA_W = UART_DATA_W
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    parameter int IRQ_THRESH = DEPTH / 2
`endif
)
(
    input  logic            clk,
    input  logic            rst,
    uart_rx_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_next_s;
    logic [PW-1:0]     rd_ptr_next_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              overrun_r;
    logic              overrun_next_s;
    logic              rise_s;
    logic              empty_s;
    logic              full_s;
    logic              pop_ok_s;
    logic              push_ok_s;
    logic              drop_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] out_data_s;

    uart_edge_detect u_valid_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.in_valid),
        .rise (rise_s)
    );

    // Occupancy flags, push/pop qualification and next pointer/overrun state.
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_ok_s  = bus.pop && !empty_s;
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        push_ok_s = rise_s && (!full_s || pop_ok_s);
        drop_s    = rise_s && full_s && !pop_ok_s && !bus.flush;
        wr_en_s   = push_ok_s && !bus.flush;

        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        if (bus.flush) begin
            wr_ptr_next_s = PTR_ZERO;
            rd_ptr_next_s = PTR_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
        end

        if (drop_s) begin
            overrun_next_s = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_next_s = 1'b0;
        end else begin
            overrun_next_s = overrun_r;
        end
    end

    // Pointer and sticky overrun state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            overrun_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            overrun_r <= overrun_next_s;
        end
    end

    // Byte storage; contents are left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= bus.in_data;
        end
    end

    // Fall-through head, forced to zero when nothing is stored.
    always_comb begin
        out_data_s = {DATA_W{1'b0}};
        if (!empty_s) begin
            out_data_s = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            out_data_s = {DATA_W{1'b0}};
        end
    end

    assign bus.out_data = out_data_s;
    assign bus.empty    = empty_s;
    assign bus.full     = full_s;
    assign bus.count    = wr_ptr_r - rd_ptr_r;
    assign bus.overrun  = overrun_r;

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [PW-1:0] IRQ_THRESH_C = IRQ_THRESH[PW-1:0];

    logic [PW-1:0] count_next_s;
    logic          irq_next_s;
    logic          irq_r;

    // Interrupt tracks next-cycle occupancy so it rises with the threshold push.
    always_comb begin
        count_next_s = wr_ptr_next_s - rd_ptr_next_s;
        if (bus.flush) begin
            irq_next_s = overrun_next_s;
        end else begin
            irq_next_s = (count_next_s >= IRQ_THRESH_C) || overrun_next_s;
        end
    end

    // Registered interrupt output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_next_s;
        end
    end

    assign bus.irq = irq_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH 16, IRQ_THRESH 8 when enabled).
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    uart_rx_fifo_if #(.DEPTH(16), .DATA_W(8)) bus ();

`ifdef UART_RX_FIFO_IRQ_EN
    uart_rx_fifo #(.DEPTH(16), .DATA_W(8), .IRQ_THRESH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    uart_rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_one;
        @(negedge clk);
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
    endtask

    task automatic pulse_flush;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.clr_overrun = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.pop = 1'b0;
        bus.flush = 1'b0; bus.clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 5'd0 ||
            bus.overrun !== 1'b0 || bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset: empty=%b full=%b count=%0d overrun=%b out=%h, expected 1 0 0 0 00",
                     bus.empty, bus.full, bus.count, bus.overrun, bus.out_data);
        end
`ifdef UART_RX_FIFO_IRQ_EN
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: irq=%b expected 0", bus.irq);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h41; exp_v[1] = 8'h42; exp_v[2] = 8'h43;
        for (int i = 0; i < 3; i++) push_byte(exp_v[i]);
        checks++;
        if (bus.count !== 5'd3) begin
            failures++;
            $display("FAIL basic_count: count=%0d expected 3", bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_data !== exp_v[i]) begin
                failures++;
                $display("FAIL basic_data%0d: out=%h expected %h", i, bus.out_data, exp_v[i]);
            end
            pop_one();
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL basic_drain: empty=%b out=%h expected 1 00", bus.empty, bus.out_data);
        end
    endtask

    task automatic test_level_hold;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (10) @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== 5'd1 || bus.out_data !== 8'h55) begin
            failures++;
            $display("FAIL level_hold: count=%0d out=%h expected 1 55", bus.count, bus.out_data);
        end
        pop_one();
    endtask

    task automatic test_full_overrun;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push_byte(8'hAA);
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overrun !== 1'b1 ||
            bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL full_drop: full=%b count=%0d overrun=%b out=%h expected 1 16 1 00",
                     bus.full, bus.count, bus.overrun, bus.out_data);
        end
        pulse_clr();
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL clr_overrun: overrun=%b expected 0", bus.overrun);
        end
        // Drop and clear together: the drop must win.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'hBB; bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.clr_overrun = 1'b0;
        checks++;
        if (bus.overrun !== 1'b1 || bus.count !== 5'd16) begin
            failures++;
            $display("FAIL set_wins: overrun=%b count=%0d expected 1 16", bus.overrun, bus.count);
        end
        pulse_clr();
    endtask

    task automatic test_full_push_pop;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h99; bus.pop = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.pop = 1'b0;
        checks++;
        if (bus.count !== 5'd16 || bus.overrun !== 1'b0 || bus.out_data !== 8'h01) begin
            failures++;
            $display("FAIL full_push_pop: count=%0d overrun=%b out=%h expected 16 0 01",
                     bus.count, bus.overrun, bus.out_data);
        end
        repeat (15) pop_one();
        checks++;
        if (bus.out_data !== 8'h99 || bus.count !== 5'd1) begin
            failures++;
            $display("FAIL full_tail: out=%h count=%0d expected 99 1", bus.out_data, bus.count);
        end
        pop_one();
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        pop_one();
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            failures++;
            $display("FAIL pop_empty: empty=%b count=%0d expected 1 0", bus.empty, bus.count);
        end
        for (int i = 0; i < 40; i++) begin
            d = 8'h30 + 8'(i);
            push_byte(d);
            checks++;
            if (bus.count !== 5'd1 || bus.out_data !== d) begin
                failures++;
                $display("FAIL wrap_push%0d: count=%0d out=%h expected 1 %h",
                         i, bus.count, bus.out_data, d);
            end
            pop_one();
            checks++;
            if (bus.count !== 5'd0) begin
                failures++;
                $display("FAIL wrap_pop%0d: count=%0d expected 0", i, bus.count);
            end
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        checks++;
        if (bus.count !== 5'd5) begin
            failures++;
            $display("FAIL flush_pre: count=%0d expected 5", bus.count);
        end
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77;
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL flush_push: count=%0d empty=%b overrun=%b expected 0 1 0",
                     bus.count, bus.empty, bus.overrun);
        end
        push_byte(8'h66);
        checks++;
        if (bus.count !== 5'd1 || bus.out_data !== 8'h66) begin
            failures++;
            $display("FAIL after_flush: count=%0d out=%h expected 1 66", bus.count, bus.out_data);
        end
        for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i));
        pulse_flush();
        checks++;
        if (bus.empty !== 1'b1 || bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL flush_keeps_overrun: empty=%b overrun=%b expected 1 1",
                     bus.empty, bus.overrun);
        end
        pulse_clr();
    endtask

`ifdef UART_RX_FIFO_IRQ_EN
    task automatic test_irq;
        for (int i = 0; i < 7; i++) push_byte(8'h20 + 8'(i));
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_below: irq=%b expected 0", bus.irq);
        end
        push_byte(8'h27);
        checks++;
        if (bus.irq !== 1'b1 || bus.count !== 5'd8) begin
            failures++;
            $display("FAIL irq_thresh: irq=%b count=%0d expected 1 8", bus.irq, bus.count);
        end
        pulse_flush();
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_flush: irq=%b expected 0", bus.irq);
        end
    endtask
`endif

    task automatic test_reset_mid;
        push_byte(8'h5A);
        push_byte(8'h5B);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h5C;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: count=%0d empty=%b expected 0 1", bus.count, bus.empty);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_inflight: count=%0d out=%h expected 0 00", bus.count, bus.out_data);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_level_hold();
        test_full_overrun();
        test_full_push_pop();
        test_wrap();
        test_flush();
`ifdef UART_RX_FIFO_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART receiver and the bus-facing UART peripheral register.
- Captures each byte the receiver flags ready into a circular FIFO.
- The peripheral read path pops bytes from the FIFO, so back-to-back characters are not lost while the CPU is busy.
- Reports count, full and empty status, plus a sticky overrun flag.

Parameters:
DEPTH, 16, number of byte entries; power of two, 2..256
DATA_W, 8, byte width; fixed to the UART character size

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  receiver ready strobe; level or pulse accepted
in_data  input  DATA_W  received byte, stable while in_valid high
pop  input  1  read strobe from bus side; removes head entry
flush  input  1  synchronous clear of FIFO contents
clr_overrun  input  1  clears overrun flag
out_data  output  DATA_W  head entry (first-word fall-through)
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: byte dropped because FIFO was full

Behaviour:
- Reset (asynchronous): all pointers = 0, edge register = 0, overrun = 0. Outputs after reset: empty = 1, full = 0, count = 0, out_data = 0. Memory contents are not reset.
- Push event: in_valid = 1 and the registered previous in_valid = 0 (rising edge). One push per ready assertion, regardless of how long in_valid stays high.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits with an extra wrap bit.
  - count = wr_ptr - rd_ptr, modulo arithmetic.
  - empty: pointers equal.
  - full: address bits equal and wrap bits differ.
  - Index wrap from DEPTH-1 to 0 is natural.
- Push, not full: mem[wr_ptr] <= in_data; wr_ptr increments at the same clock edge.
- Push while full, with no pop that cycle: byte dropped, contents unchanged, overrun <= 1.
- Pop, not empty: rd_ptr increments. out_data shows the next entry the cycle after.
- Pop while empty: ignored, no state change.
- Push and pop in the same cycle:
  - When full: pop retires the head and push is accepted; count stays DEPTH; no overrun.
  - When empty: pop ignored, push accepted; count becomes 1.
  - Otherwise: both performed; count unchanged.
- out_data:
  - Combinational read of mem[rd_ptr] when not empty; 0 when empty.
  - A pushed byte is visible on out_data the cycle after the push edge; latency 1 clock from in_valid rising to empty = 0.
- flush:
  - wr_ptr and rd_ptr <= 0. Overrides push and pop in the same cycle; the edge register still updates.
  - overrun is unaffected.
- overrun:
  - Set by a dropped push.
  - Cleared by clr_overrun. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: asynchronous, immediate, to the reset values above. A push in flight is lost.

Optional Feature:
UART_RX_FIFO_IRQ_EN
- Defined:
  - Adds parameter IRQ_THRESH (default DEPTH/2, range 1..DEPTH).
  - Adds output irq (1 bit) = registered (count_next >= IRQ_THRESH) || overrun_next. irq therefore rises in the same cycle count reaches the threshold.
  - irq resets to 0 and is held 0 during flush unless overrun = 1.
- Undefined: no IRQ_THRESH parameter, no irq port, no related logic.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W = 8.
  - UART_RX_FIFO_DEPTH_DEF = 16.
  - Status-register bit positions for the peripheral read: EMPTY = 0, FULL = 1, OVERRUN = 2, COUNT starting at bit 8.
- One sub-module: uart_edge_detect, which registers in_valid and emits a one-cycle rise pulse; reused for tx_ready handling.
- Storage stays inline in uart_rx_fifo.

Test Plan:
1. Reset, then push 0x41, 0x42, 0x43 as single-cycle in_valid pulses -> count = 3; pop three times reads 0x41, 0x42, 0x43; empty = 1, out_data = 0.
2. Hold in_valid high 10 cycles with in_data = 0x55 -> exactly one entry; count = 1.
3. Push 16 bytes 0x00..0x0F, then push 0xAA -> full = 1, count = 16, overrun = 1; head still 0x00; pulse clr_overrun -> overrun = 0.
4. Full FIFO, push 0x99 and pop in the same cycle -> count stays 16, overrun = 0; after 15 further pops out_data = 0x99.
5. Pop on empty, then 40 push/pop pairs to cross pointer wrap twice -> no underflow, data order preserved, count never exceeds 1.
6. Count = 5, assert flush together with a push -> count = 0, empty = 1, overrun unchanged. With UART_RX_FIFO_IRQ_EN and IRQ_THRESH = 8: irq rises on the 8th push.
